// File: rtl/dds_pkg.sv
// Shared DDS constants and types used by the generator and the tone meter.
package dds_pkg;
  localparam int TABLE_LEN = 1024;
  localparam int MID_DEF   = 128;
  localparam int HYST_DEF  = 8;

  typedef enum logic [1:0] {UNKNOWN, LOW, HIGH} xstate_e;
endpackage

// File: rtl/dds_tone_meter_if.sv
// Sample stream in, measurement results out, for the DDS tone meter.
interface dds_tone_meter_if;
  logic        Enable;
  logic [7:0]  Sample;
  logic [31:0] M_est;
  logic [31:0] Count;
  logic        Valid;
  logic        Overrange;

  modport master (output Enable, Sample, input M_est, Count, Valid, Overrange);
  modport slave  (input Enable, Sample, output M_est, Count, Valid, Overrange);
endinterface

// File: rtl/dds_xing_det.sv
// Input register plus hysteretic midpoint crossing detector; xing pulses on LOW->HIGH.
module dds_xing_det
  import dds_pkg::*;
#(
  parameter int MID  = MID_DEF,
  parameter int HYST = HYST_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       enable,
  input  logic [7:0] sample,
  output logic       xing
);
  localparam logic [7:0] LO_TH = 8'(MID - HYST);
  localparam logic [7:0] HI_TH = 8'(MID + HYST);

  logic [7:0] s_q;
  xstate_e    st;

  always_ff @(posedge CLK) begin
    if (RST) begin
      s_q  <= '0;
      st   <= UNKNOWN;
      xing <= 1'b0;
    end else begin
      s_q  <= sample;
      xing <= 1'b0;
      if (!enable) begin
        st <= UNKNOWN;
      end else begin
        // in-band samples hold state, which is what suppresses noise double counts
        case (st)
          UNKNOWN: if (s_q <= LO_TH) st <= LOW;
                   else if (s_q >= HI_TH) st <= HIGH;
          LOW:     if (s_q >= HI_TH) begin
                     st   <= HIGH;
                     xing <= 1'b1;
                   end
          HIGH:    if (s_q <= LO_TH) st <= LOW;
          default: st <= UNKNOWN;
        endcase
      end
    end
  end
endmodule

// File: rtl/dds_tone_meter.sv
// Recovers the DDS tuning word by counting rising crossings over a fixed gate of
// TABLE_LEN << AVG_LOG2 clocks.
module dds_tone_meter
  import dds_pkg::*;
#(
  parameter int AVG_LOG2 = 0,
  parameter int MID      = MID_DEF,
  parameter int HYST     = HYST_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  dds_tone_meter_if.slave  bus
);
  localparam int              GW      = $clog2(TABLE_LEN) + AVG_LOG2;
  localparam logic [GW-1:0]   G_LAST  = '1;
  localparam logic [31:0]     OVR_LIM = 32'd512 << AVG_LOG2;

  logic          xing;
  logic [GW-1:0] g;
  logic [31:0]   acc, acc_nxt;
  logic          settle;

  dds_xing_det #(.MID(MID), .HYST(HYST)) u_det (
    .CLK    (CLK),
    .RST    (RST),
    .enable (bus.Enable),
    .sample (bus.Sample),
    .xing   (xing)
  );

  // saturating add; also the window result on the terminal cycle
  assign acc_nxt = (xing && !(&acc)) ? acc + 32'd1 : acc;

  always_ff @(posedge CLK) begin
    if (RST) begin
      g             <= '0;
      acc           <= '0;
      settle        <= 1'b1;
      bus.M_est     <= '0;
      bus.Count     <= '0;
      bus.Valid     <= 1'b0;
      bus.Overrange <= 1'b0;
    end else begin
      bus.Valid <= 1'b0;
      if (!bus.Enable) begin
        g      <= '0;
        acc    <= '0;
        settle <= 1'b1;
      end else begin
        g <= g + 1'b1;
        if (g == G_LAST) begin
          acc    <= '0;
          settle <= 1'b0;
          // first window after enable may hold a partial crossing history
          if (!settle) begin
            bus.Count     <= acc_nxt;
            bus.M_est     <= acc_nxt >> AVG_LOG2;
            bus.Overrange <= acc_nxt > OVR_LIM;
            bus.Valid     <= 1'b1;
          end
        end else begin
          acc <= acc_nxt;
        end
      end
    end
  end
endmodule

// File: tb/tb_dds_tone_meter.sv
// Bench for dds_tone_meter: two instances (AVG_LOG2 0 and 2) share one stimulus stream.
module tb_dds_tone_meter;
  localparam int LO_TH = 120;
  localparam int HI_TH = 136;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  dds_tone_meter_if bus0();
  dds_tone_meter_if bus1();

  dds_tone_meter #(.AVG_LOG2(0), .MID(128), .HYST(8)) dut0 (.CLK(CLK), .RST(RST), .bus(bus0));
  dds_tone_meter #(.AVG_LOG2(2), .MID(128), .HYST(8)) dut1 (.CLK(CLK), .RST(RST), .bus(bus1));

  int checks = 0, errors = 0;
  int cq[$];        // per-sample rising-crossing flags since Enable rose
  int hst = 0;      // 0 unknown, 1 below band, 2 above band
  int run = 0;      // enabled clocks since last reset/enable rise
  int vmis, rmis, nres0, nres1, exp_last0, lm_obs, lm_exp;

  function automatic logic [7:0] dds(int p);
    real r;
    r = 128.0 + 127.0 * $sin(6.283185307179586 * real'(p % 1024) / 1024.0);
    return 8'(int'(r));
  endfunction

  // sum of crossings whose completing sample landed in the closing window
  function automatic int wsum(int g);
    int s = 0;
    for (int k = cq.size() - 2 - g; k <= cq.size() - 3; k++) s += cq[k];
    return s;
  endfunction

  task automatic step(input logic [7:0] s, input logic en, input logic rs);
    int  e;
    logic ev;
    bus0.Sample = s; bus1.Sample = s;
    bus0.Enable = en; bus1.Enable = en;
    RST = rs;
    @(posedge CLK);
    if (rs || !en) begin
      hst = 0; cq.delete(); run = 0;
    end else begin
      int f = 0;
      run++;
      if (s <= LO_TH) hst = 1;
      else if (s >= HI_TH) begin
        if (hst == 1) f = 1;
        hst = 2;
      end
      cq.push_back(f);
      if (cq.size() > 8200) void'(cq.pop_front());
    end
    #1;
    ev = (run >= 2048) && (run % 1024 == 0);
    if (bus0.Valid !== ev) vmis++;
    if (ev && bus0.Valid) begin
      e = wsum(1024); exp_last0 = e; nres0++;
      if (bus0.Count !== 32'(e) || bus0.M_est !== 32'(e) || bus0.Overrange !== (e > 512)) begin
        rmis++; lm_obs = int'(bus0.Count); lm_exp = e;
      end
    end
    ev = (run >= 8192) && (run % 4096 == 0);
    if (bus1.Valid !== ev) vmis++;
    if (ev && bus1.Valid) begin
      e = wsum(4096); nres1++;
      if (bus1.Count !== 32'(e) || bus1.M_est !== 32'(e >> 2) || bus1.Overrange !== (e > 2048)) begin
        rmis++; lm_obs = int'(bus1.Count); lm_exp = e;
      end
    end
  endtask

  task automatic start_test();
    vmis = 0; rmis = 0; nres0 = 0; nres1 = 0; lm_obs = 0; lm_exp = 0;
    for (int i = 0; i < 2; i++) step(8'd0, 1'b0, 1'b1);
  endtask

  task automatic run_dds(input int n, input int st, input int m, input int k0, input bit nz);
    for (int k = 0; k < n; k++) begin
      int v;
      v = int'(dds(st + (k0 + k) * m));
      if (nz) v = v + int'($urandom_range(14)) - 7;
      if (v < 0) v = 0;
      if (v > 255) v = 255;
      step(8'(v), 1'b1, 1'b0);
    end
  endtask

  task automatic test_reset();
    start_test();
    step(8'd200, 1'b1, 1'b1);
    checks++; if (bus0.Valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0d want 0", bus0.Valid); end
    checks++; if (bus0.Count !== 32'd0) begin errors++; $display("FAIL rst_count got %0d want 0", bus0.Count); end
    checks++; if (bus0.M_est !== 32'd0) begin errors++; $display("FAIL rst_mest got %0d want 0", bus0.M_est); end
    checks++; if (bus0.Overrange !== 1'b0) begin errors++; $display("FAIL rst_ovr got %0d want 0", bus0.Overrange); end
    checks++; if (bus1.Count !== 32'd0) begin errors++; $display("FAIL rst_count1 got %0d want 0", bus1.Count); end
  endtask

  task automatic test_m5();
    start_test();
    run_dds(5120, 0, 5, 0, 1'b0);
    checks++; if (vmis !== 0) begin errors++; $display("FAIL m5_valid_timing got %0d want 0", vmis); end
    checks++; if (rmis !== 0) begin errors++; $display("FAIL m5_result got %0d want %0d", lm_obs, lm_exp); end
    checks++; if (nres0 !== 4) begin errors++; $display("FAIL m5_nvalid got %0d want 4", nres0); end
    checks++; if (bus0.Count !== 32'd5) begin errors++; $display("FAIL m5_count got %0d want 5", bus0.Count); end
    checks++; if (bus0.M_est !== 32'd5) begin errors++; $display("FAIL m5_mest got %0d want 5", bus0.M_est); end
    checks++; if (bus0.Overrange !== 1'b0) begin errors++; $display("FAIL m5_ovr got %0d want 0", bus0.Overrange); end
  endtask

  task automatic test_m37_avg();
    start_test();
    run_dds(12288, 700, 37, 0, 1'b0);
    checks++; if (vmis !== 0) begin errors++; $display("FAIL m37_valid_timing got %0d want 0", vmis); end
    checks++; if (rmis !== 0) begin errors++; $display("FAIL m37_result got %0d want %0d", lm_obs, lm_exp); end
    checks++; if (nres1 !== 2) begin errors++; $display("FAIL m37_nvalid_avg got %0d want 2", nres1); end
    checks++; if (nres0 !== 11) begin errors++; $display("FAIL m37_nvalid got %0d want 11", nres0); end
    checks++; if (bus1.Count !== 32'd148) begin errors++; $display("FAIL m37_count_avg got %0d want 148", bus1.Count); end
    checks++; if (bus1.M_est !== 32'd37) begin errors++; $display("FAIL m37_mest_avg got %0d want 37", bus1.M_est); end
    checks++; if (bus0.Count !== 32'd37) begin errors++; $display("FAIL m37_count got %0d want 37", bus0.Count); end
  endtask

  task automatic test_noise();
    start_test();
    run_dds(4096, 123, 5, 0, 1'b1);
    checks++; if (vmis !== 0) begin errors++; $display("FAIL noise_valid_timing got %0d want 0", vmis); end
    checks++; if (rmis !== 0) begin errors++; $display("FAIL noise_result got %0d want %0d", lm_obs, lm_exp); end
    checks++; if (nres0 !== 3) begin errors++; $display("FAIL noise_nvalid got %0d want 3", nres0); end
    checks++; if (bus0.M_est !== 32'd5) begin errors++; $display("FAIL noise_mest got %0d want 5", bus0.M_est); end
  endtask

  task automatic test_terminal_xing();
    int st = 0;
    // choose a phase whose crossing completes on the closing sample of the window
    for (int s = 0; s < 1024; s++)
      if (dds(s + 2045 * 5) >= 8'(HI_TH) && dds(s + 2044 * 5) < 8'(HI_TH)) begin
        st = s; break;
      end
    start_test();
    run_dds(4096, st, 5, 0, 1'b0);
    checks++; if (vmis !== 0) begin errors++; $display("FAIL term_valid_timing got %0d want 0", vmis); end
    checks++; if (rmis !== 0) begin errors++; $display("FAIL term_result got %0d want %0d", lm_obs, lm_exp); end
    checks++; if (nres0 !== 3) begin errors++; $display("FAIL term_nvalid got %0d want 3", nres0); end
    checks++; if (bus0.Count !== 32'd5) begin errors++; $display("FAIL term_count got %0d want 5", bus0.Count); end
  endtask

  task automatic test_overrange_gate();
    int held;
    start_test();
    run_dds(3072, 0, 600, 0, 1'b0);
    held = exp_last0;
    checks++; if (bus0.Count !== 32'(held)) begin errors++; $display("FAIL m600_count got %0d want %0d", bus0.Count, held); end
    checks++; if (bus0.Overrange !== (held > 512)) begin errors++; $display("FAIL m600_ovr got %0d want %0d", bus0.Overrange, held > 512); end
    run_dds(500, 0, 600, 3072, 1'b0);
    for (int i = 0; i < 50; i++) step(8'd0, 1'b0, 1'b0);
    run_dds(2047, 0, 600, 0, 1'b0);
    step(8'd0, 1'b0, 1'b0);
    checks++; if (bus0.Valid !== 1'b0) begin errors++; $display("FAIL gate_term_drop_valid got %0d want 0", bus0.Valid); end
    for (int i = 0; i < 300; i++) step(8'd0, 1'b0, 1'b0);
    checks++; if (bus0.Count !== 32'(held)) begin errors++; $display("FAIL gate_hold_count got %0d want %0d", bus0.Count, held); end
    checks++; if (nres0 !== 2) begin errors++; $display("FAIL gate_nvalid got %0d want 2", nres0); end
    for (int k = 0; k < 2048; k++) step((k % 2) ? 8'd255 : 8'd0, 1'b1, 1'b0);
    checks++; if (vmis !== 0) begin errors++; $display("FAIL gate_valid_timing got %0d want 0", vmis); end
    checks++; if (rmis !== 0) begin errors++; $display("FAIL gate_result got %0d want %0d", lm_obs, lm_exp); end
    checks++; if (nres0 !== 3) begin errors++; $display("FAIL fresh_nvalid got %0d want 3", nres0); end
    checks++; if (bus0.Count !== 32'd512) begin errors++; $display("FAIL maxrate_count got %0d want 512", bus0.Count); end
    checks++; if (bus0.M_est !== 32'd512) begin errors++; $display("FAIL maxrate_mest got %0d want 512", bus0.M_est); end
    checks++; if (bus0.Overrange !== 1'b0) begin errors++; $display("FAIL maxrate_ovr got %0d want 0", bus0.Overrange); end
  endtask

  task automatic test_rst_mid_and_stuck();
    start_test();
    run_dds(3000, 40, 9, 0, 1'b0);
    checks++; if (bus0.Count !== 32'd9) begin errors++; $display("FAIL pre_rst_count got %0d want 9", bus0.Count); end
    step(8'd0, 1'b1, 1'b1);
    checks++; if (bus0.Count !== 32'd0) begin errors++; $display("FAIL midrst_count got %0d want 0", bus0.Count); end
    checks++; if (bus0.M_est !== 32'd0) begin errors++; $display("FAIL midrst_mest got %0d want 0", bus0.M_est); end
    checks++; if (bus0.Valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %0d want 0", bus0.Valid); end
    checks++; if (bus0.Overrange !== 1'b0) begin errors++; $display("FAIL midrst_ovr got %0d want 0", bus0.Overrange); end
    nres0 = 0;
    for (int k = 0; k < 2048; k++) step(8'd128, 1'b1, 1'b0);
    checks++; if (vmis !== 0) begin errors++; $display("FAIL stuck_valid_timing got %0d want 0", vmis); end
    checks++; if (nres0 !== 1) begin errors++; $display("FAIL stuck_nvalid got %0d want 1", nres0); end
    checks++; if (bus0.Count !== 32'd0) begin errors++; $display("FAIL stuck_count got %0d want 0", bus0.Count); end
    checks++; if (bus0.M_est !== 32'd0) begin errors++; $display("FAIL stuck_mest got %0d want 0", bus0.M_est); end
  endtask

  initial begin
    RST = 1'b1;
    bus0.Enable = 1'b0; bus1.Enable = 1'b0;
    bus0.Sample = 8'd0; bus1.Sample = 8'd0;
    test_reset();
    test_m5();
    test_m37_avg();
    test_noise();
    test_terminal_xing();
    test_overrange_gate();
    test_rst_mid_and_stuck();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
